period_error_filter: RTL and testbench
======================================

// Module: period_error_filter
// PURPOSE
//   Digital loop filter stage of the ADPLL, directly downstream of SaveCounter.
//   - Consumes each saved edge count and its one-cycle counter_cleared strobe.
//   - Forms a signed period error against a programmable target count.
//   - Runs a saturating proportional-integral filter on that error.
//   - Emits a DCO control word with a valid pulse, a lock indication and a sticky overrun flag.
// PARAMETERS
//   WIDTH       20       width of saved count and target
//   CTRL_WIDTH  16       width of DCO control word (unsigned)
//   INT_WIDTH   32       integrator width (signed, saturating)
//   KP_SHIFT    2        proportional gain = 2^-KP_SHIFT (arithmetic shift right)
//   KI_SHIFT    6        integral gain = 2^-KI_SHIFT (arithmetic shift right)
//   CENTRE      16'h8000 control word when error and integrator are zero
//   LOCK_TOL    2        |error| <= LOCK_TOL counts as in-tolerance
//   LOCK_COUNT  8        consecutive in-tolerance samples needed to assert lock
// PORTS
//   fpga_clk_i           in   1           system clock, all logic rising-edge
//   reset_n_i            in   1           asynchronous active-low reset
//   enable_i             in   1           loop enable; low = hold/clear
//   target_i             in   WIDTH       expected count per reference period (unsigned)
//   counter_val_saved_i  in   WIDTH       saved count from SaveCounter (unsigned)
//   counter_cleared_i    in   1           one-cycle strobe: new saved count valid
//   ctrl_word_o          out  CTRL_WIDTH  DCO control word
//   ctrl_valid_o         out  1           one-cycle pulse when ctrl_word_o updates
//   lock_o               out  1           loop locked
//   overrun_o            out  1           sticky: a strobe arrived while busy
// BEHAVIOUR
//   Reset (async, reset_n_i low):
//     - ctrl_word_o = CENTRE; ctrl_valid_o = 0; lock_o = 0; overrun_o = 0.
//     - Integrator = 0; lock counter = 0; FSM = IDLE.
//     - Any in-flight sample is discarded.
//   FSM: IDLE -> ERR -> INTEG -> OUT -> IDLE.
//     - IDLE: counter_cleared_i=1 and enable_i=1 -> capture saved count and target,
//       go to ERR. Strobe with enable_i=0 is ignored; overrun_o is not set.
//     - ERR: err = $signed({1'b0,saved}) - $signed({1'b0,target}), WIDTH+1 bits signed.
//     - INTEG: integ = sat_INT_WIDTH(integ + err), sign-extended.
//       Clamps at the signed INT_WIDTH limits and never wraps.
//     - OUT: sum = CENTRE + (err>>>KP_SHIFT) + (integ>>>KI_SHIFT), computed in
//       INT_WIDTH+2 bits, clamped to [0, 2^CTRL_WIDTH-1].
//       Register into ctrl_word_o; pulse ctrl_valid_o for 1 cycle.
//   Latency: strobe at cycle N -> ctrl_valid_o high at cycle N+3.
//     - ctrl_word_o is stable between pulses.
//   Strobe while FSM != IDLE:
//     - The strobe is dropped and overrun_o <= 1 (sticky until reset).
//     - The in-flight sample completes unaffected.
//   Strobe in the same cycle the FSM is in OUT: counts as busy, so it is dropped.
//   Lock, updated in OUT:
//     - |err| <= LOCK_TOL -> lock counter increments, saturating at LOCK_COUNT.
//       lock_o = 1 when the counter reaches LOCK_COUNT, visible with that ctrl_valid_o.
//     - Otherwise the counter is cleared and lock_o = 0 with that ctrl_valid_o.
//   enable_i low, any state:
//     - Next cycle: FSM = IDLE, integrator = 0, lock counter = 0, lock_o = 0,
//       ctrl_word_o = CENTRE.
//     - No ctrl_valid_o pulse; an in-flight sample is aborted; overrun_o is kept.
//   Sign convention: a count above target raises ctrl_word_o.
//     DCO polarity is handled downstream.
// TESTING
//   1. target=10, saved=10 strobe -> 3 cycles later ctrl_valid_o=1, ctrl_word_o=0x8000.
//   2. Continue from 1: saved=14 -> err=4, integ=4, ctrl_word_o=0x8001.
//      Then saved=14 again -> integ=8, ctrl=0x8001.
//   3. Saturation:
//      - target=0, saved=0xFFFFF -> ctrl_word_o=0xFFFF.
//      - After reset, target=0xFFFFF, saved=0 -> ctrl_word_o=0x0000.
//      - Repeated 5000 strobes -> integrator clamps, no wrap.
//   4. Lock:
//      - 8 strobes with err=0 -> lock_o rises with the 8th valid.
//      - Then err=5 -> lock_o=0 with that valid.
//      - Then err=-2 -> counter restarts at 1.
//   5. Overrun: strobes at cycle 0 and cycle 2 -> single valid at cycle 3,
//      overrun_o=1 and stays 1 until reset.
//   6. Aborts:
//      - reset_n_i low at cycle N+1 after a strobe -> outputs at reset values immediately,
//        no valid.
//      - enable_i low mid-sample -> no valid, ctrl_word_o=0x8000.

Source files
------------

// File: rtl/period_error_filter.sv
// ADPLL loop filter: turns each saved edge count into a period error, runs a
// saturating PI filter on it and produces the DCO control word and lock status.
module period_error_filter #(
  parameter int unsigned           WIDTH      = 20,
  parameter int unsigned           CTRL_WIDTH = 16,
  parameter int unsigned           INT_WIDTH  = 32,
  parameter int unsigned           KP_SHIFT   = 2,
  parameter int unsigned           KI_SHIFT   = 6,
  parameter logic [CTRL_WIDTH-1:0] CENTRE     = 16'h8000,
  parameter int unsigned           LOCK_TOL   = 2,
  parameter int unsigned           LOCK_COUNT = 8
) (
  input  logic                  fpga_clk_i,
  input  logic                  reset_n_i,
  input  logic                  enable_i,
  input  logic [WIDTH-1:0]      target_i,
  input  logic [WIDTH-1:0]      counter_val_saved_i,
  input  logic                  counter_cleared_i,
  output logic [CTRL_WIDTH-1:0] ctrl_word_o,
  output logic                  ctrl_valid_o,
  output logic                  lock_o,
  output logic                  overrun_o
);

  localparam int unsigned CNT_W = $clog2(LOCK_COUNT + 1);
  localparam logic signed [INT_WIDTH-1:0] INT_MAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic signed [INT_WIDTH-1:0] INT_MIN = {1'b1, {(INT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ERR, S_INTEG, S_OUT} state_t;

  state_t                        state_q, state_d;
  logic [WIDTH-1:0]              saved_q, target_q;
  logic signed [WIDTH:0]         err_q, err_d;
  logic signed [INT_WIDTH-1:0]   integ_q, integ_sat, i_term;
  logic signed [INT_WIDTH:0]     integ_sum;
  logic signed [WIDTH:0]         p_term;
  logic signed [INT_WIDTH+1:0]   ctrl_sum;
  logic [CTRL_WIDTH-1:0]         ctrl_sat;
  logic [WIDTH:0]                err_abs;
  logic                          in_tol;
  logic [CNT_W-1:0]              lock_cnt_q, lock_cnt_inc;
  logic                          busy_strobe;

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (counter_cleared_i) state_d = S_ERR;
        S_ERR:   state_d = S_INTEG;
        S_INTEG: state_d = S_OUT;
        S_OUT:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy_strobe = enable_i && counter_cleared_i && (state_q != S_IDLE);

  always_comb begin
    err_d     = $signed({1'b0, saved_q}) - $signed({1'b0, target_q});
    integ_sum = {integ_q[INT_WIDTH-1], integ_q} +
                {{(INT_WIDTH-WIDTH){err_q[WIDTH]}}, err_q};
    if (integ_sum[INT_WIDTH] != integ_sum[INT_WIDTH-1])
      integ_sat = integ_sum[INT_WIDTH] ? INT_MIN : INT_MAX;
    else
      integ_sat = integ_sum[INT_WIDTH-1:0];
    p_term   = err_q >>> KP_SHIFT;
    i_term   = integ_sat >>> KI_SHIFT;
    ctrl_sum = {{(INT_WIDTH+2-CTRL_WIDTH){1'b0}}, CENTRE} +
               {{(INT_WIDTH+1-WIDTH){p_term[WIDTH]}}, p_term} +
               {{2{i_term[INT_WIDTH-1]}}, i_term};
    if (ctrl_sum[INT_WIDTH+1])                   ctrl_sat = '0;
    else if (|ctrl_sum[INT_WIDTH:CTRL_WIDTH])    ctrl_sat = '1;
    else                                         ctrl_sat = ctrl_sum[CTRL_WIDTH-1:0];
    err_abs      = err_q[WIDTH] ? $unsigned(-err_q) : $unsigned(err_q);
    in_tol       = (err_abs <= (WIDTH+1)'(LOCK_TOL));
    lock_cnt_inc = (lock_cnt_q == CNT_W'(LOCK_COUNT)) ? lock_cnt_q : lock_cnt_q + 1'b1;
  end

  // Integrator, control word and lock all commit on the INTEG->OUT edge so the
  // valid pulse lands three cycles after the strobe with its matching lock state.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      saved_q      <= '0;
      target_q     <= '0;
      err_q        <= '0;
      integ_q      <= '0;
      lock_cnt_q   <= '0;
      ctrl_word_o  <= CENTRE;
      ctrl_valid_o <= 1'b0;
      lock_o       <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      ctrl_valid_o <= 1'b0;
      if (busy_strobe) overrun_o <= 1'b1;
      if (!enable_i) begin
        integ_q     <= '0;
        lock_cnt_q  <= '0;
        lock_o      <= 1'b0;
        ctrl_word_o <= CENTRE;
      end else begin
        unique case (state_q)
          S_IDLE: if (counter_cleared_i) begin
            saved_q  <= counter_val_saved_i;
            target_q <= target_i;
          end
          S_ERR: err_q <= err_d;
          S_INTEG: begin
            integ_q      <= integ_sat;
            ctrl_word_o  <= ctrl_sat;
            ctrl_valid_o <= 1'b1;
            if (in_tol) begin
              lock_cnt_q <= lock_cnt_inc;
              lock_o     <= (lock_cnt_inc == CNT_W'(LOCK_COUNT));
            end else begin
              lock_cnt_q <= '0;
              lock_o     <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_period_error_filter.sv
// Self-checking bench for period_error_filter against a behavioural PI/lock model.
module tb_period_error_filter;

  localparam longint INT_MAX_M = 64'sd2147483647;
  localparam longint INT_MIN_M = -64'sd2147483648;

  logic        fpga_clk_i = 1'b0;
  logic        reset_n_i  = 1'b0;
  logic        enable_i   = 1'b0;
  logic [19:0] target_i   = '0;
  logic [19:0] counter_val_saved_i = '0;
  logic        counter_cleared_i   = 1'b0;
  logic [15:0] ctrl_word_o;
  logic        ctrl_valid_o;
  logic        lock_o;
  logic        overrun_o;

  int n_checks = 0;
  int n_fails  = 0;
  int n_valid  = 0;

  longint m_integ    = 0;
  int     m_lock_cnt = 0;

  period_error_filter dut (
    .fpga_clk_i          (fpga_clk_i),
    .reset_n_i           (reset_n_i),
    .enable_i            (enable_i),
    .target_i            (target_i),
    .counter_val_saved_i (counter_val_saved_i),
    .counter_cleared_i   (counter_cleared_i),
    .ctrl_word_o         (ctrl_word_o),
    .ctrl_valid_o        (ctrl_valid_o),
    .lock_o              (lock_o),
    .overrun_o           (overrun_o)
  );

  always #5 fpga_clk_i = ~fpga_clk_i;

  always @(negedge fpga_clk_i) if (ctrl_valid_o) n_valid++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: error, clamped integrator, gain by floor shifts, clamped output.
  task automatic model_sample(input longint saved, input longint target,
                              output longint ctrl, output bit lock);
    longint err, sum;
    err = saved - target;
    m_integ = m_integ + err;
    if (m_integ > INT_MAX_M) m_integ = INT_MAX_M;
    if (m_integ < INT_MIN_M) m_integ = INT_MIN_M;
    sum = 32768 + (err >>> 2) + (m_integ >>> 6);
    if (sum < 0) sum = 0;
    if (sum > 65535) sum = 65535;
    ctrl = sum;
    if (err >= -2 && err <= 2) m_lock_cnt = (m_lock_cnt < 8) ? m_lock_cnt + 1 : 8;
    else m_lock_cnt = 0;
    lock = (m_lock_cnt == 8);
  endtask

  task automatic model_clear();
    m_integ = 0;
    m_lock_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge fpga_clk_i);
    reset_n_i = 1'b0;
    counter_cleared_i = 1'b0;
    repeat (2) @(negedge fpga_clk_i);
    reset_n_i = 1'b1;
    model_clear();
  endtask

  task automatic do_sample(input logic [19:0] saved, input logic [19:0] target, input string tag);
    longint exp_ctrl;
    bit     exp_lock;
    int     lat;
    model_sample(longint'(saved), longint'(target), exp_ctrl, exp_lock);
    @(negedge fpga_clk_i);
    counter_val_saved_i = saved;
    target_i = target;
    counter_cleared_i = 1'b1;
    @(posedge fpga_clk_i);
    #1 counter_cleared_i = 1'b0;
    lat = 1;
    while (!ctrl_valid_o && lat < 8) begin
      @(posedge fpga_clk_i);
      #1 lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_ctrl"}, ctrl_word_o, exp_ctrl);
    check({tag, "_lock"}, lock_o, exp_lock);
    @(posedge fpga_clk_i);
    #1 check({tag, "_pulse"}, ctrl_valid_o, 0);
  endtask

  initial begin
    int v0;
    logic [19:0] t, s;

    #12;
    check("rst_ctrl", ctrl_word_o, 16'h8000);
    check("rst_valid", ctrl_valid_o, 0);
    check("rst_lock", lock_o, 0);
    check("rst_overrun", overrun_o, 0);
    reset_n_i = 1'b1;
    enable_i  = 1'b1;

    // Basic response and integrator accumulation
    do_sample(20'd10, 20'd10, "t1");
    check("t1_value", ctrl_word_o, 16'h8000);
    do_sample(20'd14, 20'd10, "t2a");
    check("t2a_value", ctrl_word_o, 16'h8001);
    do_sample(20'd14, 20'd10, "t2b");
    check("t2b_value", ctrl_word_o, 16'h8001);

    // Strobe while disabled is ignored
    @(negedge fpga_clk_i);
    enable_i = 1'b0;
    v0 = n_valid;
    counter_cleared_i = 1'b1;
    @(negedge fpga_clk_i);
    counter_cleared_i = 1'b0;
    repeat (5) @(negedge fpga_clk_i);
    check("dis_novalid", n_valid - v0, 0);
    check("dis_overrun", overrun_o, 0);
    enable_i = 1'b1;
    model_clear();

    // Output clamps
    do_reset();
    do_sample(20'hFFFFF, 20'h0, "sat_hi");
    check("sat_hi_value", ctrl_word_o, 16'hFFFF);
    do_reset();
    do_sample(20'h0, 20'hFFFFF, "sat_lo");
    check("sat_lo_value", ctrl_word_o, 16'h0000);

    // Integrator clamps at both limits without wrapping
    do_reset();
    for (int i = 0; i < 5000; i++) do_sample(20'hFFFFF, 20'h0, "int_pos");
    check("int_pos_model", m_integ, INT_MAX_M);
    do_sample(20'd100, 20'd100, "int_pos_hold");
    do_reset();
    for (int i = 0; i < 2500; i++) do_sample(20'h0, 20'hFFFFF, "int_neg");
    check("int_neg_model", m_integ, INT_MIN_M);
    do_sample(20'd300, 20'd300, "int_neg_hold");

    // Lock acquisition, loss and restart
    do_reset();
    for (int i = 0; i < 7; i++) do_sample(20'd500, 20'd500, "lock_pre");
    check("lock_pre7", lock_o, 0);
    do_sample(20'd500, 20'd500, "lock_8th");
    check("lock_8th_value", lock_o, 1);
    do_sample(20'd505, 20'd500, "lock_lost");
    check("lock_lost_value", lock_o, 0);
    do_sample(20'd498, 20'd500, "lock_restart");
    for (int i = 0; i < 6; i++) do_sample(20'd500, 20'd500, "lock_re");
    check("lock_re_7", lock_o, 0);
    do_sample(20'd501, 20'd500, "lock_re_8");
    check("lock_re_8_value", lock_o, 1);

    // Overrun: second strobe two cycles after the first is dropped
    do_reset();
    check("ovr_clear", overrun_o, 0);
    v0 = n_valid;
    begin
      longint exp_ctrl;
      bit exp_lock;
      model_sample(longint'(20'd1000), longint'(20'd900), exp_ctrl, exp_lock);
      @(negedge fpga_clk_i);
      counter_val_saved_i = 20'd1000; target_i = 20'd900; counter_cleared_i = 1'b1;
      @(posedge fpga_clk_i); #1 counter_cleared_i = 1'b0;
      @(posedge fpga_clk_i); #1 counter_val_saved_i = 20'd5; counter_cleared_i = 1'b1;
      @(posedge fpga_clk_i); #1 counter_cleared_i = 1'b0;
      check("ovr_valid_at3", ctrl_valid_o, 1);
      check("ovr_ctrl", ctrl_word_o, exp_ctrl);
      repeat (8) @(posedge fpga_clk_i);
      #1 check("ovr_single_valid", n_valid - v0, 1);
      check("ovr_sticky", overrun_o, 1);
    end
    do_sample(20'd900, 20'd900, "ovr_after");
    check("ovr_still", overrun_o, 1);

    // Reset mid-sample
    @(negedge fpga_clk_i);
    counter_val_saved_i = 20'd2000; target_i = 20'd10; counter_cleared_i = 1'b1;
    @(posedge fpga_clk_i); #1 counter_cleared_i = 1'b0;
    reset_n_i = 1'b0;
    #1;
    check("abrst_ctrl", ctrl_word_o, 16'h8000);
    check("abrst_valid", ctrl_valid_o, 0);
    check("abrst_lock", lock_o, 0);
    check("abrst_overrun", overrun_o, 0);
    v0 = n_valid;
    @(negedge fpga_clk_i); reset_n_i = 1'b1;
    model_clear();
    repeat (6) @(negedge fpga_clk_i);
    check("abrst_novalid", n_valid - v0, 0);

    // Enable drop mid-sample clears filter and lock
    do_sample(20'd400, 20'd200, "en_pre");
    for (int i = 0; i < 8; i++) do_sample(20'd202, 20'd200, "en_lock");
    check("en_locked", lock_o, 1);
    check("en_pre_ctrl", ctrl_word_o, 16'h8003);
    @(negedge fpga_clk_i);
    counter_val_saved_i = 20'd3000; target_i = 20'd10; counter_cleared_i = 1'b1;
    v0 = n_valid;
    @(posedge fpga_clk_i); #1 counter_cleared_i = 1'b0; enable_i = 1'b0;
    @(posedge fpga_clk_i); #1;
    check("en_ctrl", ctrl_word_o, 16'h8000);
    check("en_lock_clr", lock_o, 0);
    repeat (4) @(negedge fpga_clk_i);
    check("en_novalid", n_valid - v0, 0);
    enable_i = 1'b1;
    model_clear();
    do_sample(20'd64, 20'd0, "en_after");

    // Randomised samples: mostly near target, occasionally wide errors
    for (int i = 0; i < 300; i++) begin
      t = 20'($urandom_range(1000, 900000));
      if ($urandom_range(0, 7) == 0) s = 20'($urandom);
      else s = 20'(int'(t) + int'($urandom_range(0, 8)) - 4);
      do_sample(s, t, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
